// File: rtl/register_file.sv
// Multi-register storage with one write port, two combinational read ports,
// optional hardwired-zero register 0, optional write bypass and a one-register-per-cycle clear sweep.
module register_file #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [ADDR_W-1:0] read_addr_a,
  input  logic [ADDR_W-1:0] read_addr_b,
  output logic [WIDTH-1:0]  data_out_a,
  output logic [WIDTH-1:0]  data_out_b,
  input  logic              clear,
  output logic              busy,
  output logic              write_err
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_idx;
  logic [ADDR_W-1:0]  w_idx_nxt;
  logic               r_write_err;
  logic               w_write_err_nxt;
  logic [WIDTH-1:0]   r_mem [DEPTH];

  logic               w_wr_in_range;
  logic               w_wr_zero;
  logic               w_wr_commit;
  logic [ADDR_W-1:0]  w_raddr [2];
  logic [WIDTH-1:0]   w_rdata [2];

  assign w_wr_in_range = ({1'b0, write_addr} < LP_DEPTH);
  assign w_wr_zero     = ZERO_REG && (write_addr == {ADDR_W{1'b0}});
  // A write lands only from IDLE with no clear request competing for the same edge.
  assign w_wr_commit   = (r_state == ST_IDLE) && !clear && write && w_wr_in_range && !w_wr_zero;

  // Next-state, sweep index and dropped-write flag.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_write_err_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear) begin
          w_state_nxt     = ST_CLEAR;
          w_idx_nxt       = {ADDR_W{1'b0}};
          w_write_err_nxt = write;
        end else begin
          w_write_err_nxt = write && !w_wr_in_range;
        end
      end
      ST_CLEAR: begin
        w_write_err_nxt = write;
        if (r_idx == LP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = {ADDR_W{1'b0}};
        end else begin
          w_idx_nxt   = r_idx + ADDR_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= {ADDR_W{1'b0}};
      r_write_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_write_err <= w_write_err_nxt;
    end
  end

  // Storage array: the sweep zeroes one entry per edge, otherwise accept the committed write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_state == ST_CLEAR) begin
      r_mem[r_idx] <= '0;
    end else if (w_wr_commit) begin
      r_mem[write_addr] <= data_in;
    end else begin
      r_mem <= r_mem;
    end
  end

  assign w_raddr[0] = read_addr_a;
  assign w_raddr[1] = read_addr_b;

  // Read ports: out-of-range and the zero register read 0; bypass shows data_in before the edge.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rdata[p] = '0;
      if ({1'b0, w_raddr[p]} >= LP_DEPTH) begin
        w_rdata[p] = '0;
      end else if (ZERO_REG && (w_raddr[p] == {ADDR_W{1'b0}})) begin
        w_rdata[p] = '0;
      end else if (BYPASS && w_wr_commit && (w_raddr[p] == write_addr)) begin
        w_rdata[p] = data_in;
      end else begin
        w_rdata[p] = r_mem[w_raddr[p]];
      end
    end
  end

  assign data_out_a = w_rdata[0];
  assign data_out_b = w_rdata[1];
  assign busy       = (r_state == ST_CLEAR);
  assign write_err  = r_write_err;

endmodule
